// File: rtl/evt_gen_pkg.sv
// Shared state encoding, default sizing and counter-width helper for event_stream_gen.
package evt_gen_pkg;

  localparam int N_W_DEF   = 16;
  localparam int RATIO_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT0 = 2'd1,
    ST_EMIT1 = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Width that holds Cnt1*RATIO for any Cnt1 without truncation.
  function automatic int rem_w(input int n_w, input int ratio);
    return n_w + $clog2(ratio);
  endfunction

endpackage

// File: rtl/evt_down_cnt.sv
// Loadable down-counter tracking the pulses still owed in one phase of a command.
// A load with dec set accounts for a pulse launched on the same edge as the load.
module evt_down_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val - W'(dec);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/event_stream_gen.sv
// Event stream generator: expands a (Cnt0, Cnt1) command into En/Slt pulses for the dual event counter.
// Optional EVT_GAP_EN macro inserts one idle cycle between consecutive pulses.
module event_stream_gen
  import evt_gen_pkg::*;
#(
  parameter int N_W   = N_W_DEF,
  parameter int RATIO = RATIO_DEF
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           CmdValid,
  output logic           CmdReady,
  input  logic [N_W-1:0] Cnt0,
  input  logic [N_W-1:0] Cnt1,
  input  logic           Pause,
  output logic           En,
  output logic           Slt,
  output logic           Busy,
  output logic           Done
);

  localparam int REM1_W = rem_w(N_W, RATIO);

  state_e state_q, state_d;
  logic   en_q, en_d;
  logic   slt_q, slt_d;
  logic   done_q, done_d;
  logic   busy_q, busy_d;
  logic   ready_q, ready_d;

  logic              accept;
  logic              fire_ok;
  logic              load;
  logic              dec0;
  logic              dec1;
  logic              zero0;
  logic              zero1;
  logic [REM1_W-1:0] cnt1_x;

  evt_down_cnt #(.W(N_W)) u_cnt0 (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (load),
    .dec      (dec0),
    .load_val (Cnt0),
    .zero     (zero0)
  );

  evt_down_cnt #(.W(REM1_W)) u_cnt1 (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (load),
    .dec      (dec1),
    .load_val (cnt1_x),
    .zero     (zero1)
  );

  // Decides at each edge whether the following cycle carries a pulse; Slt follows the phase.
  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    load    = 1'b0;
    dec0    = 1'b0;
    dec1    = 1'b0;
    accept  = CmdValid && ready_q;
    cnt1_x  = REM1_W'(Cnt1) * REM1_W'(RATIO);
`ifdef EVT_GAP_EN
    // The previous cycle must have been idle (a paused cycle also counts).
    fire_ok = !Pause && !en_q;
`else
    fire_ok = !Pause;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load = 1'b1;
          if ((Cnt0 == '0) && (Cnt1 == '0)) begin
            state_d = ST_DONE;
          end else if (Cnt0 != '0) begin
            state_d = ST_EMIT0;
            en_d    = !Pause;
            dec0    = !Pause;
          end else begin
            state_d = ST_EMIT1;
            en_d    = !Pause;
            dec1    = !Pause;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT0: begin
        if (!zero0) begin
          en_d = fire_ok;
          dec0 = fire_ok;
        end else if (zero1) begin
          state_d = ST_DONE;
        end else if (fire_ok) begin
          // Phase switches on the edge launching the first Slt=1 pulse, so Slt stays flat per phase.
          state_d = ST_EMIT1;
          en_d    = 1'b1;
          dec1    = 1'b1;
        end else begin
          state_d = ST_EMIT0;
        end
      end
      ST_EMIT1: begin
        if (!zero1) begin
          en_d = fire_ok;
          dec1 = fire_ok;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    slt_d   = (state_d == ST_EMIT1);
    done_d  = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      slt_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      slt_q   <= slt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign En       = en_q;
  assign Slt      = slt_q;
  assign Done     = done_q;
  assign Busy     = busy_q;
  assign CmdReady = ready_q;

endmodule

// File: tb/tb_event_stream_gen.sv
// Self-checking bench for event_stream_gen: queue-based pulse model compared every cycle,
// plus directed commands with hand-computed pulse counts, En masks and Done timing.
module tb_event_stream_gen;

  localparam int R = 4;
`ifdef EVT_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] cnt0 = 16'd0;
  logic [15:0] cnt1 = 16'd0;
  logic        cmd_ready, en, slt, busy, done;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  event_stream_gen dut (
    .Clk      (clk),
    .Reset    (rst_n),
    .CmdValid (cmd_valid),
    .CmdReady (cmd_ready),
    .Cnt0     (cnt0),
    .Cnt1     (cnt1),
    .Pause    (pause),
    .En       (en),
    .Slt      (slt),
    .Busy     (busy),
    .Done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 streaming, 2 completion cycle.
  // A command becomes a queue of Slt values; one is popped per pulse.
  int m_mode = 0;
  bit m_q[$];
  bit m_en = 1'b0;
  bit m_slt = 1'b0;
  bit m_last_slt = 1'b0;
  bit m_fire;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      m_q.delete();
      m_en = 1'b0;
      m_slt = 1'b0;
      m_last_slt = 1'b0;
    end else begin
      m_fire = 1'b0;
      case (m_mode)
        0: begin
          if (cmd_valid) begin
            for (int i = 0; i < int'(cnt0); i++) m_q.push_back(1'b0);
            for (int i = 0; i < int'(cnt1) * R; i++) m_q.push_back(1'b1);
            if (m_q.size() == 0) begin
              m_mode = 2;
            end else begin
              m_mode = 1;
              m_last_slt = m_q[0];
              m_fire = !pause;
            end
          end
        end
        1: begin
          if (m_q.size() == 0) m_mode = 2;
          else m_fire = !pause && !((GAP == 1) && m_en);
        end
        default: m_mode = 0;
      endcase
      if (m_fire) m_last_slt = m_q.pop_front();
      m_en  = m_fire;
      m_slt = (m_mode == 1) ? m_last_slt : 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("en",    en,        m_en);
      check("slt",   slt,       m_slt);
      check("done",  done,      m_mode == 2);
      check("busy",  busy,      m_mode != 0);
      check("ready", cmd_ready, m_mode == 0);
    end
  end

  // Issues one command from idle and observes it until Done (bounded).
  // Cycle 1 is the cycle right after the accepting edge.
  task automatic run_cmd(input int c0, input int c1, input int p_at, input int p_len, input bit hold,
                         output int p0, output int p1, output int done_cyc,
                         output logic [31:0] mask, output int n_done);
    int cyc;
    cyc = 0;
    p0 = 0;
    p1 = 0;
    done_cyc = -1;
    mask = 32'd0;
    n_done = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cnt0 = 16'(c0);
    cnt1 = 16'(c1);
    pause = 1'b0;
    for (int i = 0; i < 200 && done_cyc < 0; i++) begin
      @(negedge clk);
      cyc++;
      if (en) begin
        if (slt) p1++;
        else p0++;
        if (cyc <= 32) mask[cyc-1] = 1'b1;
      end
      if (done) begin
        done_cyc = cyc;
        n_done++;
      end
      cmd_valid = hold && (done_cyc < 0);
      if (hold) begin
        cnt0 = 16'($urandom_range(9, 1));
        cnt1 = 16'($urandom_range(9, 1));
      end
      pause = (cyc >= p_at) && (cyc < p_at + p_len);
    end
    cmd_valid = 1'b0;
    pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
  endtask

  initial begin
    int p0, p1, dc, nd;
    logic [31:0] mk;

    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_en",    en,        1'b0);
    check("rst_slt",   slt,       1'b0);
    check("rst_busy",  busy,      1'b0);
    check("rst_done",  done,      1'b0);
    chk_on = 1'b1;
    rst_n = 1'b1;

    // (3,2): 3 Slt=0 then 8 Slt=1 pulses, Done right after.
    run_cmd(3, 2, 0, 0, 1'b0, p0, p1, dc, mk, nd);
    check("t1_out0",  p0,     3);
    check("t1_out1",  p1 / R, 2);
    check("t1_frac",  p1 % R, 0);
    check("t1_mask",  mk,     (GAP == 1) ? 32'h0015_5555 : 32'h0000_07FF);
    check("t1_done",  dc,     (GAP == 1) ? 22 : 12);
    check("t1_ndone", nd,     1);

    // (0,0): no pulses, Done one cycle after accept.
    run_cmd(0, 0, 0, 0, 1'b0, p0, p1, dc, mk, nd);
    check("t2_mask", mk, 32'd0);
    check("t2_done", dc, 1);
    check("t2_idle", cmd_ready, 1'b1);

    // (5,0) with Pause over cycles 3 and 4.
    run_cmd(5, 0, 2, 2, 1'b0, p0, p1, dc, mk, nd);
    check("t3_out0", p0, 5);
    check("t3_out1", p1, 0);
    check("t3_mask", mk, (GAP == 1) ? 32'h0000_0551 : 32'h0000_0073);
    check("t3_done", dc, (GAP == 1) ? 12 : 8);

    // Async reset during the Slt=1 phase of (2,3).
    @(negedge clk);
    cmd_valid = 1'b1;
    cnt0 = 16'd2;
    cnt1 = 16'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("t4_pre_slt",  slt,  1'b1);
    check("t4_pre_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_en",    en,        1'b0);
    check("t4_slt",   slt,       1'b0);
    check("t4_busy",  busy,      1'b0);
    check("t4_done",  done,      1'b0);
    check("t4_ready", cmd_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(1, 1, 0, 0, 1'b0, p0, p1, dc, mk, nd);
    check("t4_out0", p0, 1);
    check("t4_p1",   p1, 4);
    check("t4_cdone", dc, (GAP == 1) ? 10 : 6);

    // CmdValid held with changing fields while busy.
    run_cmd(2, 1, 0, 0, 1'b1, p0, p1, dc, mk, nd);
    check("t5_out0",  p0, 2);
    check("t5_p1",    p1, 4);
    check("t5_done",  dc, (GAP == 1) ? 12 : 7);
    check("t5_ndone", nd, 1);

    // (2,1): 6 pulses, alternating when gapped.
    run_cmd(2, 1, 0, 0, 1'b0, p0, p1, dc, mk, nd);
    check("t6_mask", mk, (GAP == 1) ? 32'h0000_0555 : 32'h0000_003F);
    check("t6_done", dc, (GAP == 1) ? 12 : 7);

    // Randomized traffic against the model, with one async reset.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cmd_valid = ($urandom_range(2, 0) == 0);
      cnt0 = 16'($urandom_range(6, 0));
      cnt1 = 16'($urandom_range(3, 0));
      pause = ($urandom_range(3, 0) == 0);
      if (i == 1000) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    pause = 1'b0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
